// File: rtl/cc_or_gate.sv
// cc_or_gate: bitwise OR with a registered copy, a rise pulse on the registered OR,
// and a saturating count of cycles where the registered result is non-zero.
module cc_or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             any_rise,
  output logic [CNT_W-1:0] hi_cnt
);
  logic any_q;
  logic prev_any;
  assign y     = a | b;
  assign any_q = |y_q;
  // prev_any holds the previous cycle's |y_q so any_rise lands one cycle after the 0->1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_q      <= '0;
      prev_any <= 1'b0;
      any_rise <= 1'b0;
      hi_cnt   <= '0;
    end else begin
      y_q      <= y;
      prev_any <= any_q;
      any_rise <= any_q & ~prev_any;
      hi_cnt   <= (any_q && !(&hi_cnt)) ? hi_cnt + 1'b1 : hi_cnt;
    end
endmodule

// File: tb/tb_cc_or_gate.sv
// tb_cc_or_gate: table-driven combinational checks under reset, then a cycle
// model feeding a scoreboard queue for the registered outputs and corner cases.
module tb_cc_or_gate;
  localparam int W = 4;
  localparam int C = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] y, y_q;
  logic any_rise;
  logic [C-1:0] hi_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] y;} vec_t;
  typedef struct {logic [W-1:0] y_q; logic rise; logic [C-1:0] cnt;} exp_t;
  exp_t sb[$];
  logic [W-1:0] m_yq;
  logic m_prev, m_rise;
  logic [C-1:0] m_cnt;

  cc_or_gate #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .y(y), .y_q(y_q), .any_rise(any_rise), .hi_cnt(hi_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic mreset();
    m_yq = '0;
    m_prev = 1'b0;
    m_rise = 1'b0;
    m_cnt = '0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t e;
    m_rise = (|m_yq) && !m_prev;
    m_prev = |m_yq;
    if ((|m_yq) && m_cnt != {C{1'b1}}) m_cnt = m_cnt + 1'b1;
    m_yq = a | b;
    e = '{m_yq, m_rise, m_cnt};
    sb.push_back(e);
  endtask

  // Called just after a negedge: drive, check the comb path and pre-edge y_q, step one edge.
  task automatic cycle(input logic [W-1:0] na, input logic [W-1:0] nb, input string n);
    exp_t e;
    a = na;
    b = nb;
    #1;
    chk({n, " y"}, y, na | nb);
    chk({n, " pre-edge y_q"}, y_q, m_yq);
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", n);
    end else begin
      e = sb.pop_front();
      chk({n, " y_q"}, y_q, e.y_q);
      chk({n, " any_rise"}, any_rise, e.rise);
      chk({n, " hi_cnt"}, hi_cnt, e.cnt);
    end
  endtask

  initial begin
    vec_t v[5];
    v = '{'{4'b0011, 4'b0101, 4'b0111},
          '{4'b1010, 4'b0101, 4'b1111},
          '{4'b0000, 4'b0010, 4'b0010},
          '{4'b0000, 4'b0000, 4'b0000},
          '{4'b1111, 4'b1111, 4'b1111}};
    mreset();
    foreach (v[i]) begin
      a = v[i].a;
      b = v[i].b;
      #10;
      chk("comb y", y, v[i].y);
      chk("reset y_q", y_q, 0);
      chk("reset any_rise", any_rise, 0);
      chk("reset hi_cnt", hi_cnt, 0);
    end
    a = '0;
    b = '0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cycle(4'h0, 4'h0, "idle");
    cycle(4'h1, 4'h0, "first rise");
    repeat (10) cycle(4'h1, 4'h0, "saturate");
    chk("saturated hi_cnt", hi_cnt, 7);
    repeat (3) cycle(4'h0, 4'h0, "hold");
    chk("held hi_cnt", hi_cnt, 7);
    repeat (40) cycle(W'($urandom), W'($urandom), "random");
    // rebuild a known state: hi_cnt=5 with y_q=1
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mreset();
    cycle(4'h0, 4'h0, "rearm");
    repeat (6) cycle(4'h1, 4'h0, "count up");
    chk("pre-reset hi_cnt", hi_cnt, 5);
    chk("pre-reset y_q", y_q, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async y_q", y_q, 0);
    chk("async any_rise", any_rise, 0);
    chk("async hi_cnt", hi_cnt, 0);
    chk("async y", y, 4'h1);
    rst_n = 1'b1;
    mreset();
    cycle(4'h1, 4'h0, "post-reset load");
    cycle(4'h1, 4'h0, "post-reset rise");
    chk("post-reset pulse", any_rise, 1);
    cycle(4'h1, 4'h0, "post-reset steady");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
